// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life pattern loader: grid geometry,
// pattern numbering, loader states and the 16-entry preset ROM.
// No ports; imported by the loader, its ROM and the write interface.
package gol_pkg;

    localparam int unsigned GRID_W = 8;
    localparam int unsigned GRID_H = 8;
    localparam int unsigned ROW_W  = $clog2(GRID_H);
    localparam int unsigned PAT_N  = 16;
    localparam int unsigned PAT_W  = $clog2(PAT_N);

    typedef logic [GRID_W-1:0] row_t;

    typedef enum logic [PAT_W-1:0] {
        PAT_CLEAR   = 4'h0,
        PAT_GLIDER  = 4'h1,
        PAT_BLINKER = 4'h2,
        PAT_BLOCK   = 4'h3,
        PAT_BEACON  = 4'h4,
        PAT_TOAD    = 4'h5,
        PAT_LWSS    = 4'h6,
        PAT_RPENT   = 4'h7,
        PAT_FULL    = 4'h8,
        PAT_CHECKER = 4'h9,
        PAT_DIAG    = 4'ha,
        PAT_BORDER  = 4'hb,
        PAT_HLINE   = 4'hc,
        PAT_VLINE   = 4'hd,
        PAT_CROSS   = 4'he,
        PAT_CORNER  = 4'hf
    } pattern_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_DONE     = 2'd2,
        ST_WAIT_REL = 2'd3
    } ld_state_e;

    // Row data, bit 7 = leftmost column; index order is [pattern][row].
    localparam row_t PAT_ROM [PAT_N][GRID_H] = '{
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, // clear
        '{8'h40, 8'h20, 8'he0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, // glider
        '{8'h00, 8'h00, 8'h00, 8'h1c, 8'h00, 8'h00, 8'h00, 8'h00}, // blinker
        '{8'h00, 8'h00, 8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00}, // block
        '{8'h00, 8'h60, 8'h60, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00}, // beacon
        '{8'h00, 8'h00, 8'h38, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00}, // toad
        '{8'h00, 8'h00, 8'h24, 8'h40, 8'h44, 8'h78, 8'h00, 8'h00}, // LWSS
        '{8'h00, 8'h00, 8'h0c, 8'h18, 8'h08, 8'h00, 8'h00, 8'h00}, // R-pentomino
        '{8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff}, // full
        '{8'haa, 8'h55, 8'haa, 8'h55, 8'haa, 8'h55, 8'haa, 8'h55}, // checkerboard
        '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}, // diagonal
        '{8'hff, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hff}, // border
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'hff, 8'h00, 8'h00, 8'h00}, // horizontal line
        '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10}, // vertical line
        '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81}, // X cross
        '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}  // top-left cell
    };

endpackage

// File: rtl/gol_pattern_loader_if.sv
// Row-write channel from the pattern loader into the Game-of-Life grid.
// master (loader): drives wr_en, wr_row, wr_data; samples wr_ready.
// slave  (grid)  : samples the write, drives wr_ready.
interface gol_pattern_loader_if;

    logic                        wr_en;
    logic [gol_pkg::ROW_W-1:0]   wr_row;
    logic [gol_pkg::GRID_W-1:0]  wr_data;
    logic                        wr_ready;

    modport master (
        output wr_en,
        output wr_row,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_row,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/gol_pattern_rom.sv
// Combinational preset lookup: (pattern, row) -> 8-bit row of cells.
// pat_i  : pattern number
// row_i  : row index, 0 = top
// data_o : row cells, bit 7 = column 0
module gol_pattern_rom
    import gol_pkg::*;
(
    input  logic [PAT_W-1:0]  pat_i,
    input  logic [ROW_W-1:0]  row_i,
    output logic [GRID_W-1:0] data_o
);

    assign data_o = PAT_ROM[pat_i][row_i];

endmodule

// File: rtl/gol_pattern_loader.sv
// Turns the keypad's repeating draw strobe into exactly one 8-row preset load
// into the Game-of-Life grid per key press, with busy/done status for the engine.
// clk, rst  : clock, synchronous active-high reset
// pattern   : pattern number from the keypad selector
// draw      : draw strobe, re-pulses every scan while the key is held
// wr        : row-write channel (master side)
// busy      : high while rows are being written
// done      : one-cycle pulse after the last row is accepted
module gol_pattern_loader
    import gol_pkg::*;
#(
    parameter int unsigned HOLDOFF = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PAT_W-1:0]      pattern,
    input  logic                  draw,
    gol_pattern_loader_if.master  wr,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned REL_W = $clog2(HOLDOFF + 1);

    ld_state_e          state_q;
    logic [PAT_W-1:0]   sel_q;
    logic [PAT_W-1:0]   load_pat_q;
    logic [ROW_W-1:0]   row_q;
    logic [ROW_W-1:0]   row_d;
    logic [REL_W-1:0]   rel_q;
    logic               wr_en_q;
    logic [ROW_W-1:0]   wr_row_q;
    logic [GRID_W-1:0]  wr_data_q;
    logic               busy_q;
    logic               done_q;

    logic               accept_c;
    logic [PAT_W-1:0]   rom_pat_c;
    logic [ROW_W-1:0]   rom_row_c;
    logic [GRID_W-1:0]  rom_data_c;

    // ROM is addressed one row ahead so wr_data can be registered with the row it belongs to.
    always_comb begin
        accept_c  = wr_en_q && wr.wr_ready;
        row_d     = row_q + ROW_W'(1);
        rom_pat_c = load_pat_q;
        rom_row_c = row_d;
        if (state_q == ST_IDLE) begin
            rom_pat_c = sel_q;
            rom_row_c = '0;
        end
    end

    gol_pattern_rom u_rom (
        .pat_i  (rom_pat_c),
        .row_i  (rom_row_c),
        .data_o (rom_data_c)
    );

    // Loader FSM, selection latch, row/release counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            load_pat_q <= '0;
            row_q      <= '0;
            rel_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_row_q   <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // The selector zeroes pattern when draw rises, so only track it while draw is low.
            if (!draw) begin
                sel_q <= pattern;
            end
            done_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (draw) begin
                        load_pat_q <= sel_q;
                        row_q      <= '0;
                        wr_en_q    <= 1'b1;
                        wr_row_q   <= '0;
                        wr_data_q  <= rom_data_c;
                        busy_q     <= 1'b1;
                        state_q    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (accept_c) begin
                        if (row_q == ROW_W'(GRID_H - 1)) begin
                            row_q     <= '0;
                            wr_en_q   <= 1'b0;
                            wr_row_q  <= '0;
                            wr_data_q <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            row_q     <= row_d;
                            wr_row_q  <= row_d;
                            wr_data_q <= rom_data_c;
                        end
                    end
                end
                ST_DONE: begin
                    rel_q   <= '0;
                    state_q <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    // A held key re-pulses draw every scan and keeps clearing this count.
                    if (draw) begin
                        rel_q <= '0;
                    end else if (rel_q == REL_W'(HOLDOFF - 1)) begin
                        rel_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        rel_q <= rel_q + REL_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr.wr_en   = wr_en_q;
    assign wr.wr_row  = wr_row_q;
    assign wr.wr_data = wr_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_gol_pattern_loader.sv
// Scoreboard bench for gol_pattern_loader: a cycle-level behavioural model queues the
// expected write/done for each output cycle; a negedge monitor compares the DUT against it.
module tb_gol_pattern_loader;

    localparam int HOLDOFF = 8;

    logic       clk;
    logic       rst;
    logic [3:0] pattern;
    logic       draw;
    logic       busy;
    logic       done;

    gol_pattern_loader_if bus ();

    gol_pattern_loader #(.HOLDOFF(HOLDOFF)) dut (
        .clk     (clk),
        .rst     (rst),
        .pattern (pattern),
        .draw    (draw),
        .wr      (bus),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       is_done;
        bit [2:0] row;
        bit [7:0] data;
        int       cyc;
    } exp_t;

    typedef enum int { M_AVAIL, M_LOAD, M_FINISH, M_COOL } mode_t;

    exp_t  exp_q[$];
    mode_t m_mode;
    int    m_sel, m_pat, m_row, m_quiet;
    int    cyc;
    int    n_checks, n_pass, n_done;
    bit    rand_rdy;

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
    endtask

    // Cell shapes described as coordinates, independent of any row encoding.
    function automatic bit alive(input int p, input int r, input int c);
        case (p)
            1:  return (r == 0 && c == 1) || (r == 1 && c == 2) || (r == 2 && c <= 2);
            2:  return r == 3 && c >= 3 && c <= 5;
            3:  return (r == 3 || r == 4) && (c == 3 || c == 4);
            4:  return ((r == 1 || r == 2) && (c == 1 || c == 2)) ||
                       ((r == 3 || r == 4) && (c == 3 || c == 4));
            5:  return (r == 2 && c >= 2 && c <= 4) || (r == 3 && c >= 1 && c <= 3);
            6:  return (r == 2 && (c == 2 || c == 5)) || (r == 3 && c == 1) ||
                       (r == 4 && (c == 1 || c == 5)) || (r == 5 && c >= 1 && c <= 4);
            7:  return (r == 2 && (c == 4 || c == 5)) || (r == 3 && (c == 3 || c == 4)) ||
                       (r == 4 && c == 4);
            8:  return 1'b1;
            9:  return ((r + c) % 2) == 0;
            10: return r == c;
            11: return r == 0 || r == 7 || c == 0 || c == 7;
            12: return r == 4;
            13: return c == 3;
            14: return r == c || r + c == 7;
            15: return r == 0 && c == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit [7:0] ref_row(input int p, input int r);
        bit [7:0] b;
        b = '0;
        for (int c = 0; c < 8; c++) if (alive(p, r, c)) b[7-c] = 1'b1;
        return b;
    endfunction

    function automatic void push_row();
        exp_t e;
        e.is_done = 1'b0;
        e.row     = 3'(m_row);
        e.data    = ref_row(m_pat, m_row);
        e.cyc     = cyc;
        exp_q.push_back(e);
    endfunction

    // Reference model: predicts what the DUT presents in the cycle after each edge.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_mode = M_AVAIL; m_sel = 0; m_pat = 0; m_row = 0; m_quiet = 0;
            exp_q.delete();
        end else begin
            case (m_mode)
                M_AVAIL: if (draw) begin
                    m_pat = m_sel; m_row = 0; m_mode = M_LOAD; push_row();
                end
                M_LOAD: begin
                    if (bus.wr_ready && m_row == 7) begin
                        exp_t e;
                        e.is_done = 1'b1; e.row = '0; e.data = '0; e.cyc = cyc;
                        exp_q.push_back(e);
                        m_mode = M_FINISH;
                    end else begin
                        if (bus.wr_ready) m_row++;
                        push_row();
                    end
                end
                M_FINISH: begin m_mode = M_COOL; m_quiet = 0; end
                M_COOL: begin
                    if (draw) m_quiet = 0;
                    else begin
                        m_quiet++;
                        if (m_quiet == HOLDOFF) m_mode = M_AVAIL;
                    end
                end
                default: m_mode = M_AVAIL;
            endcase
            if (!draw) m_sel = int'(pattern);
        end
    end

    // Monitor: compare the DUT outputs against the queued expectation for this cycle.
    always @(negedge clk) begin
        exp_t e;
        chk("busy", int'(busy), int'(m_mode == M_LOAD));
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            chk("wr_en", int'(bus.wr_en), int'(!e.is_done));
            chk("done", int'(done), int'(e.is_done));
            if (!e.is_done) begin
                chk("wr_row", int'(bus.wr_row), int'(e.row));
                chk("wr_data", int'(bus.wr_data), int'(e.data));
            end
        end else begin
            chk("idle_wr_en", int'(bus.wr_en), 0);
            chk("idle_done", int'(done), 0);
        end
        if (done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_rdy) bus.wr_ready = ($urandom_range(0, 99) < 70);
    endtask

    task automatic select(input int p, input int n);
        pattern = 4'(p); draw = 1'b0;
        repeat (n) tick();
    endtask

    task automatic press();
        draw = 1'b1; pattern = 4'd0;
        tick();
        draw = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        draw = 1'b0;
        while ((exp_q.size() != 0 || m_mode != M_AVAIL) && k < 400) begin
            tick();
            k++;
        end
        chk(name, int'(k < 400), 1);
    endtask

    initial begin
        int d0, k, p, scans;
        n_checks = 0; n_pass = 0; n_done = 0; cyc = 0; rand_rdy = 1'b0;
        m_mode = M_AVAIL; m_sel = 0; m_pat = 0; m_row = 0; m_quiet = 0;
        rst = 1'b1; pattern = 4'd0; draw = 1'b0; bus.wr_ready = 1'b1;
        repeat (3) tick();
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_wr_row", int'(bus.wr_row), 0);
        chk("rst_wr_data", int'(bus.wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        rst = 1'b0;
        tick();

        // Glider with selector zeroing pattern on the draw cycle.
        select(1, 3); press();
        drain("glider_drain");

        // Held key: one load only.
        d0 = n_done;
        select(3, 3);
        for (int i = 0; i < 60; i++) begin
            draw = (i % 4 == 0);
            pattern = draw ? 4'd0 : 4'd3;
            tick();
        end
        drain("held_drain");
        chk("held_key_loads", n_done - d0, 1);

        // Backpressure for two cycles on row 2 of blinker.
        select(2, 3); press();
        tick(); tick();
        bus.wr_ready = 1'b0;
        tick(); tick();
        chk("bp_row_held", int'(bus.wr_row), 2);
        chk("bp_data_held", int'(bus.wr_data), 0);
        bus.wr_ready = 1'b1;
        drain("bp_drain");

        // Re-trigger boundary around HOLDOFF.
        select(5, 3); press();
        k = 0;
        while (!done && k < 50) begin @(negedge clk); k++; end
        chk("retrig_done_seen", int'(done), 1);
        @(posedge clk); #2;
        draw = 1'b0; pattern = 4'd7;
        repeat (HOLDOFF - 1) tick();
        press();
        chk("retrig_short_ignored", int'(busy), 0);
        pattern = 4'd7;
        repeat (HOLDOFF) tick();
        press();
        chk("retrig_full_starts", int'(busy), 1);
        drain("retrig_drain");

        // Reset in the middle of a glider load; next load uses the reset selection.
        select(1, 3); press();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("midrst_wr_en", int'(bus.wr_en), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        rst = 1'b0;
        draw = 1'b1; pattern = 4'd3;
        tick();
        draw = 1'b0; pattern = 4'd0;
        drain("midrst_drain");

        // Pattern switched during row 1 of glider.
        select(1, 3); press();
        tick();
        pattern = 4'd2;
        drain("patchg_drain");

        // Randomized presses, holds, gaps and backpressure.
        rand_rdy = 1'b1;
        for (int n = 0; n < 20; n++) begin
            p = $urandom_range(0, 15);
            select(p, $urandom_range(1, 3));
            scans = $urandom_range(1, 4);
            for (int s = 0; s < scans; s++) begin
                press();
                repeat (3) tick();
            end
            k = $urandom_range(0, 14);
            for (int g = 0; g < k; g++) begin
                pattern = 4'($urandom_range(0, 15));
                tick();
            end
        end
        drain("random_drain");
        rand_rdy = 1'b0;
        bus.wr_ready = 1'b1;
        tick();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
